// File: rtl/req_dispatcher.sv
// Pops requests from the shared request FIFO and hands each one to unit 1 or unit 2,
// chosen by req_buf[OP_BIT]. Optional per-unit counters under REQ_DISPATCH_STATS_EN.
module req_dispatcher #(
   parameter int unsigned REQ_WIDTH = 32,
   parameter int unsigned OP_BIT    = REQ_WIDTH - 1,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_fifo_empty,
   output logic                 req_fifo_rd_en,
   input  logic [REQ_WIDTH-1:0] req_fifo_data,
   output logic                 req_valid_1,
   output logic [REQ_WIDTH-1:0] req_data_1,
   input  logic                 req_ready_1,
   output logic                 req_valid_2,
   output logic [REQ_WIDTH-1:0] req_data_2,
   input  logic                 req_ready_2,
   output logic                 busy
`ifdef REQ_DISPATCH_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] dispatch_cnt_1,
   output logic [CNT_WIDTH-1:0] dispatch_cnt_2
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      FETCH    = 2'b01,
      DISPATCH = 2'b10
   } state_e;

   state_e               state_q, state_d;
   logic [REQ_WIDTH-1:0] req_buf_q, req_buf_d;
   logic                 in_dispatch;
   logic                 to_unit2;
   logic                 hs_1, hs_2;

   if (OP_BIT >= REQ_WIDTH) begin : g_bad_op_bit
      $error("req_dispatcher: OP_BIT must index into the request word");
   end
   if (CNT_WIDTH == 0) begin : g_bad_cnt_width
      $error("req_dispatcher: CNT_WIDTH must be non-zero");
   end

   // Outputs decode only state_q and req_buf_q, so there is no path from ready to valid/data.
   always_comb begin
      in_dispatch = (state_q == DISPATCH);
      to_unit2    = req_buf_q[OP_BIT];
      req_valid_1 = in_dispatch && !to_unit2;
      req_valid_2 = in_dispatch && to_unit2;
      req_data_1  = req_valid_1 ? req_buf_q : '0;
      req_data_2  = req_valid_2 ? req_buf_q : '0;
      hs_1        = req_valid_1 && req_ready_1;
      hs_2        = req_valid_2 && req_ready_2;
      busy        = (state_q != IDLE);
   end

   always_comb begin
      state_d        = state_q;
      req_buf_d      = req_buf_q;
      req_fifo_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            req_fifo_rd_en = !req_fifo_empty;
            if (!req_fifo_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            req_buf_d = req_fifo_data;
            state_d   = DISPATCH;
         end
         DISPATCH: begin
            // Next pop overlaps the accepting cycle to sustain one request per two cycles.
            if (hs_1 || hs_2) begin
               req_fifo_rd_en = !req_fifo_empty;
               state_d        = req_fifo_empty ? IDLE : FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_buf_q <= '0;
      end else begin
         state_q   <= state_d;
         req_buf_q <= req_buf_d;
      end
   end

`ifdef REQ_DISPATCH_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_1_q, cnt_1_d;
   logic [CNT_WIDTH-1:0] cnt_2_q, cnt_2_d;

   // Saturating counters: hold at all-ones instead of wrapping.
   always_comb begin
      cnt_1_d = cnt_1_q;
      cnt_2_d = cnt_2_q;
      if (hs_1 && (cnt_1_q != '1)) begin
         cnt_1_d = cnt_1_q + 1'b1;
      end
      if (hs_2 && (cnt_2_q != '1)) begin
         cnt_2_d = cnt_2_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_1_q <= '0;
         cnt_2_q <= '0;
      end else begin
         cnt_1_q <= cnt_1_d;
         cnt_2_q <= cnt_2_d;
      end
   end

   assign dispatch_cnt_1 = cnt_1_q;
   assign dispatch_cnt_2 = cnt_2_q;
`endif

endmodule

// File: tb/tb_req_dispatcher.sv
// Scoreboard bench for req_dispatcher: stimulus queues expected handshakes, a negedge
// monitor pops and checks them. Counter checks run when REQ_DISPATCH_STATS_EN is defined.
module tb_req_dispatcher;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_fifo_empty;
   logic          req_fifo_rd_en;
   logic [W-1:0]  req_fifo_data = '0;
   logic          req_valid_1, req_valid_2;
   logic [W-1:0]  req_data_1, req_data_2;
   logic          req_ready_1 = 1'b0;
   logic          req_ready_2 = 1'b0;
   logic          busy;
`ifdef REQ_DISPATCH_STATS_EN
   logic [CW-1:0] dispatch_cnt_1, dispatch_cnt_2;
`endif

   req_dispatcher #(
      .REQ_WIDTH (W),
      .OP_BIT    (W - 1),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_fifo_empty (req_fifo_empty),
      .req_fifo_rd_en (req_fifo_rd_en),
      .req_fifo_data  (req_fifo_data),
      .req_valid_1    (req_valid_1),
      .req_data_1     (req_data_1),
      .req_ready_1    (req_ready_1),
      .req_valid_2    (req_valid_2),
      .req_data_2     (req_data_2),
      .req_ready_2    (req_ready_2),
      .busy           (busy)
`ifdef REQ_DISPATCH_STATS_EN
      ,
      .dispatch_cnt_1 (dispatch_cnt_1),
      .dispatch_cnt_2 (dispatch_cnt_2)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: data appears the cycle after the pop, like a registered read port.
   logic [W-1:0] fifo_mem [0:63];
   int unsigned  wp = 0;
   int unsigned  rp = 0;
   assign req_fifo_empty = (rp == wp);
   always @(posedge clk) begin
      if (req_fifo_rd_en) begin
         req_fifo_data <= fifo_mem[rp % 64];
         rp            <= rp + 1;
      end
   end

   typedef struct {
      logic        unit2;
      logic [W-1:0] data;
      int unsigned cyc;
   } exp_t;
   exp_t exp_q[$];

   // Requests raised by stimulus, serviced by the monitor at the next negedge.
   logic        chk_idle    = 1'b0;
   logic        chk_level   = 1'b0;
   logic        chk_drained = 1'b0;
   logic        chk_cnt     = 1'b0;
   logic        timeout_ev  = 1'b0;
   int unsigned exp_level   = 0;
   int unsigned exp_cnt1    = 0;
   int unsigned exp_cnt2    = 0;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   logic         prev_held = 1'b0;
   logic [1:0]   prev_v    = '0;
   logic [W-1:0] prev_d    = '0;

   always @(negedge clk) begin
      logic hs;
      exp_t e;
      if (!rst_n) begin
         prev_held = 1'b0;
      end else begin
         if (req_fifo_rd_en) chk("rd_en_while_empty", 32'(req_fifo_empty), 32'd0);
         if (req_valid_1 || req_valid_2) begin
            chk("both_valid", 32'(req_valid_1 && req_valid_2), 32'd0);
            chk("other_data_zero", req_valid_1 ? req_data_2 : req_data_1, 32'd0);
         end
         if (prev_held) begin
            chk("hold_valid", 32'({req_valid_1, req_valid_2}), 32'(prev_v));
            chk("hold_data", req_valid_1 ? req_data_1 : req_data_2, prev_d);
         end
         hs = (req_valid_1 && req_ready_1) || (req_valid_2 && req_ready_2);
         if (hs) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_handshake at cycle %0d: got data %h expected none",
                        cyc, req_valid_1 ? req_data_1 : req_data_2);
            end else begin
               e = exp_q.pop_front();
               chk("hs_unit2", 32'(req_valid_2), 32'(e.unit2));
               chk("hs_data", req_valid_2 ? req_data_2 : req_data_1, e.data);
               chk("hs_cycle", cyc, e.cyc);
            end
         end
         prev_held = (req_valid_1 || req_valid_2) && !hs;
         prev_v    = {req_valid_1, req_valid_2};
         prev_d    = req_valid_1 ? req_data_1 : req_data_2;
      end

      if (chk_idle) begin
         chk("idle_rd_en", 32'(req_fifo_rd_en), 32'd0);
         chk("idle_valid_1", 32'(req_valid_1), 32'd0);
         chk("idle_valid_2", 32'(req_valid_2), 32'd0);
         chk("idle_data_1", req_data_1, 32'd0);
         chk("idle_data_2", req_data_2, 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      if (chk_level) chk("fifo_level", wp - rp, exp_level);
      if (chk_drained) begin
         chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
         chk("fifo_drained", wp - rp, 32'd0);
      end
`ifdef REQ_DISPATCH_STATS_EN
      if (chk_cnt) begin
         chk("dispatch_cnt_1", 32'(dispatch_cnt_1), exp_cnt1);
         chk("dispatch_cnt_2", 32'(dispatch_cnt_2), exp_cnt2);
      end
`endif
      if (timeout_ev) begin
         total++;
         bad++;
         $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, exp_q.size());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a check flag for exactly one monitor negedge.
   task automatic pulse_flag(output logic f);
      f = 1'b1;
      @(negedge clk);
      #1;
      f = 1'b0;
   endtask

   task automatic push_req(input logic [W-1:0] w);
      fifo_mem[wp % 64] = w;
      wp++;
   endtask

   task automatic expect_hs(input logic u2, input logic [W-1:0] d, input int unsigned c);
      exp_t e;
      e.unit2 = u2;
      e.data  = d;
      e.cyc   = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n = 0;
      while (((exp_q.size() != 0) || busy) && (n < budget)) begin
         tick();
         n++;
      end
      if ((exp_q.size() != 0) || busy) begin
         pulse_flag(timeout_ev);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k;

      // reset values
      tick();
      pulse_flag(chk_idle);
`ifdef REQ_DISPATCH_STATS_EN
      exp_cnt1 = 0;
      exp_cnt2 = 0;
      pulse_flag(chk_cnt);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      // single request to unit 1
      req_ready_1 = 1'b1;
      req_ready_2 = 1'b0;
      k = cyc;
      push_req(32'h0000_0ABC);
      expect_hs(1'b0, 32'h0000_0ABC, k + 2);
      wait_drain(20);
      tick();
      pulse_flag(chk_idle);

      // back-pressure on unit 2, second request queued behind it
      tick();
      req_ready_2 = 1'b0;
      k = cyc;
      push_req(32'h8000_0001);
      expect_hs(1'b1, 32'h8000_0001, k + 7);
      repeat (3) tick();
      push_req(32'h0000_0007);
      expect_hs(1'b0, 32'h0000_0007, k + 9);
      repeat (3) tick();
      exp_level = 1;
      pulse_flag(chk_level);
      tick();
      req_ready_2 = 1'b1;
      wait_drain(30);
      pulse_flag(chk_drained);

      // back-to-back alternating units
      tick();
      req_ready_1 = 1'b1;
      req_ready_2 = 1'b1;
      k = cyc;
      push_req(32'h0000_0001);
      push_req(32'h8000_0002);
      push_req(32'h0000_0003);
      expect_hs(1'b0, 32'h0000_0001, k + 2);
      expect_hs(1'b1, 32'h8000_0002, k + 4);
      expect_hs(1'b0, 32'h0000_0003, k + 6);
      wait_drain(30);
      pulse_flag(chk_drained);

      // ready from the wrong unit is ignored
      tick();
      req_ready_1 = 1'b0;
      req_ready_2 = 1'b1;
      k = cyc;
      push_req(32'h0000_0005);
      expect_hs(1'b0, 32'h0000_0005, k + 5);
      repeat (5) tick();
      req_ready_1 = 1'b1;
      wait_drain(30);
      pulse_flag(chk_drained);

      // reset while a request waits in DISPATCH: that request is dropped
      tick();
      req_ready_1 = 1'b0;
      push_req(32'h0000_0BAD);
      repeat (3) tick();
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      pulse_flag(chk_idle);
      tick();
      req_ready_1 = 1'b1;
      rst_n = 1'b1;
      repeat (4) pulse_flag(chk_idle);

`ifdef REQ_DISPATCH_STATS_EN
      // saturating counters after the reset above
      tick();
      req_ready_1 = 1'b1;
      req_ready_2 = 1'b1;
      k = cyc;
      for (int i = 0; i < 5; i++) begin
         push_req(32'h0000_0010 + 32'(i));
         expect_hs(1'b0, 32'h0000_0010 + 32'(i), k + 2 + 2 * i);
      end
      push_req(32'h8000_0020);
      expect_hs(1'b1, 32'h8000_0020, k + 12);
      wait_drain(40);
      exp_cnt1 = 3;
      exp_cnt2 = 1;
      pulse_flag(chk_cnt);
`endif

      tick();
      pulse_flag(chk_drained);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/req_dispatcher.md
# req_dispatcher

Request-side counterpart of the response arbiter. It pops requests from the single shared request FIFO and routes each one to one of two processing units over a valid/ready handshake. The routing is selected by one opcode bit. It sits between the host request FIFO and the alloc/free engines, whose responses are later merged by the response arbiter.

## Interface
- REQ_WIDTH, 32, request word width
- OP_BIT, REQ_WIDTH-1, bit index of the request word that selects the target: 0 selects unit 1, 1 selects unit 2
- CNT_WIDTH, 16, statistics counter width (used only with REQ_DISPATCH_STATS_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_fifo_empty  in  1  request FIFO empty flag
- req_fifo_rd_en  out  1  FIFO pop; FIFO data is valid the cycle after the pop
- req_fifo_data  in  REQ_WIDTH  FIFO read data
- req_valid_1  out  1  request valid to unit 1
- req_data_1  out  REQ_WIDTH  request word to unit 1
- req_ready_1  in  1  unit 1 accepts
- req_valid_2  out  1  request valid to unit 2
- req_data_2  out  REQ_WIDTH  request word to unit 2
- req_ready_2  in  1  unit 2 accepts
- busy  out  1  high whenever state is not IDLE
- dispatch_cnt_1  out  CNT_WIDTH  count of requests accepted by unit 1 (macro only)
- dispatch_cnt_2  out  CNT_WIDTH  count of requests accepted by unit 2 (macro only)

## Operation
- State machine has three states: IDLE, FETCH, DISPATCH. Encoding is 2 bits; the unused encoding returns to IDLE.
- **IDLE:** req_fifo_rd_en = !req_fifo_empty (combinational). When it is asserted, go to FETCH.
- **FETCH:**
  - Register req_fifo_data into req_buf.
  - Go to DISPATCH unconditionally.
  - req_fifo_rd_en = 0.
- **DISPATCH:**
  - Target is unit 1 if req_buf[OP_BIT] = 0, otherwise unit 2.
  - Only the target's valid is high. Only the target's data equals req_buf; the other unit's data is 0.
  - Handshake completes when the target's ready is high.
  - On handshake with !req_fifo_empty: assert req_fifo_rd_en in the same cycle and go to FETCH (back-to-back).
  - On handshake with the FIFO empty: go to IDLE.
  - Without handshake: stay in DISPATCH. Valid and data are held stable.
- Ready from the non-target unit is ignored in all states.
- Ready asserted in IDLE or FETCH is ignored.
- req_fifo_rd_en is never asserted while req_fifo_empty = 1.
- At most one request is in flight (popped but not yet accepted).
- Valid and data outputs are decoded from state and req_buf, so they have no combinational path from ready.

## Timing
- Reset values:
  - state = IDLE, req_buf = 0
  - req_fifo_rd_en = 0, both valids = 0, both data = 0, busy = 0
  - counters = 0
- Latency: req_fifo_empty falls in cycle N → rd_en in cycle N, capture in N+1, valid from N+2.
- Sustained throughput with ready tied high is one request per 2 cycles.
- The next request's rd_en coincides with the current handshake cycle.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous).
  - A request already popped but not accepted is dropped.
  - This loss is required behaviour, not a bug.

## Configuration
- **REQ_DISPATCH_STATS_EN defined:**
  - dispatch_cnt_1 and dispatch_cnt_2 exist.
  - Each increments by 1 on its unit's handshake cycle.
  - Each saturates at all-ones (no wrap).
  - Both clear only on reset.
- **REQ_DISPATCH_STATS_EN undefined:** the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Single request to unit 1:** FIFO holds 0x0000_0ABC, ready_1 = 1.
  - rd_en for 1 cycle.
  - valid_1 2 cycles later for exactly 1 cycle with data_1 = 0x0000_0ABC.
  - valid_2 = 0 throughout; busy returns to 0.
- **Back-pressure on unit 2:** request 0x8000_0001, ready_2 held low 5 cycles then high.
  - valid_2 and data_2 stable for 6 cycles.
  - No rd_en until the handshake, even though the FIFO is non-empty.
- **Back-to-back alternating:** FIFO holds 0x1, 0x8000_0002, 0x3, both readies high.
  - valid_1, valid_2, valid_1 at cycles 2, 4, 6.
  - rd_en at cycles 0, 2, 4 and never while empty.
- **Wrong-unit ready:** request 0x5 with ready_1 = 0 and ready_2 = 1.
  - Stays in DISPATCH with no handshake.
  - When ready_1 rises, the handshake occurs.
- **Reset mid-operation:** assert rst_n low while in DISPATCH.
  - All outputs go to 0 immediately.
  - After release with the FIFO empty, no valid is asserted.
- **Statistics (REQ_DISPATCH_STATS_EN, CNT_WIDTH = 2):**
  - 5 requests to unit 1 → dispatch_cnt_1 = 3 (saturated).
  - 1 request to unit 2 → dispatch_cnt_2 = 1.
